// File: rtl/lin_predist.sv
// N-channel amplitude-dependent gain/phase predistorter. |x|^2 indexes a
// host-written breakpoint table; interpolated gain and phase correct each I/Q beat.
module lin_predist #(
    parameter  int NCH = 2,
    parameter  int DW  = 16,
    parameter  int AW  = 17,
    parameter  int CW  = 16,
    parameter  int TAW = 5,
    parameter  int FW  = 8,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    input  logic                 i_iq,
    input  logic [CHW-1:0]       i_chan,
    input  logic signed [DW-1:0] i_cart,
    input  logic [AW-1:0]        i_angl,
    input  logic                 mode,
    input  logic                 tbl_we,
    input  logic [TAW-1:0]       tbl_addr,
    input  logic [2*CW-1:0]      tbl_data,
    input  logic                 err_clr,
    output logic                 o_valid,
    output logic [CHW-1:0]       o_chan,
    output logic signed [DW-1:0] o_i,
    output logic signed [DW-1:0] o_q,
    output logic [AW-1:0]        o_angl,
    output logic                 err
);

    localparam int TDEPTH = 1 << TAW;
    localparam logic signed [CW-1:0]    UNITY   = {2'b01, {(CW-2){1'b0}}};
    localparam logic signed [DW+CW-1:0] SAT_MAX = {{(CW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [DW+CW-1:0] SAT_MIN = -SAT_MAX;

    typedef struct packed {
        logic [CHW-1:0]       chan;
        logic signed [DW-1:0] i;
        logic signed [DW-1:0] q;
        logic [AW-1:0]        angl;
    } carry_t;

    // ---------------- input side: per-channel I slots ----------------
    logic                 chan_ok;
    logic                 i_word;
    logic                 q_word;
    logic                 q_hit;
    logic                 proto_err;
    logic [NCH-1:0]       pending;
    logic [DW-2:0]        i_abs;
    logic [2*DW-3:0]      i_sq;

    logic signed [DW-1:0] slot_i    [NCH];
    logic [AW-1:0]        slot_angl [NCH];
    logic [2*DW-3:0]      slot_i2   [NCH];

    assign chan_ok   = int'(i_chan) < NCH;
    assign i_word    = i_valid & ~i_iq & chan_ok;
    assign q_word    = i_valid &  i_iq & chan_ok;
    assign q_hit     = q_word & pending[i_chan];
    assign proto_err = (i_valid & ~chan_ok) | (i_word & pending[i_chan]) | (q_word & ~pending[i_chan]);

    // The most negative sample is clipped upstream, so |x| fits DW-1 bits.
    assign i_abs = i_cart[DW-1] ? (DW-1)'(-i_cart) : i_cart[DW-2:0];
    assign i_sq  = (2*DW-2)'(i_abs) * (2*DW-2)'(i_abs);

    // NOTE: slot storage has no reset; pending[] gates every read, so stale data is never used.
    always_ff @(posedge clk) begin
        if (i_word) begin
            slot_i[i_chan]    <= i_cart;
            slot_angl[i_chan] <= i_angl;
            slot_i2[i_chan]   <= i_sq;
        end
    end

    // ---------------- breakpoint table ----------------
    logic signed [CW-1:0] tbl_g [TDEPTH];
    logic signed [CW-1:0] tbl_p [TDEPTH];

    // NOTE: this register-file memory is reset on purpose so an unconfigured table is identity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < TDEPTH; e++) begin
                tbl_g[e] <= UNITY;
                tbl_p[e] <= '0;
            end
        end else if (tbl_we) begin
            tbl_g[tbl_addr] <= tbl_data[2*CW-1 -: CW];
            tbl_p[tbl_addr] <= tbl_data[CW-1:0];
        end
    end

    // ---------------- pipeline registers ----------------
    logic                    s0_v, s1_v, s2_v, s3_v, s4_v, s5_v, s6_v;
    carry_t                  s0, s1, s2, s3, s4, s5;
    logic                    s0_mode, s1_mode, s2_mode;
    logic [2*DW-3:0]         s0_i2, s1_i2, s1_q2;
    logic [TAW-1:0]          s2_k;
    logic [FW-1:0]           s2_f, s3_f;
    logic signed [CW-1:0]    s3_g0, s3_g1, s3_p0, s3_p1;
    logic signed [CW-1:0]    s4_g0, s4_p0;
    logic signed [CW+FW+1:0] s4_dg_prod, s4_dp_prod;
    logic signed [CW-1:0]    s5_g, s5_p;
    logic [CHW-1:0]          s6_chan;
    logic signed [DW+CW-1:0] s6_prod_i, s6_prod_q;
    logic [AW-1:0]           s6_angl;

    logic [DW-2:0]           q_abs;
    logic [2*DW-3:0]         q_sq;
    logic [TAW+FW-1:0]       mag2_kf;
    logic [TAW-1:0]          k_nxt;
    logic signed [CW:0]      dg, dp;
    logic signed [FW:0]      f_s;

    assign q_abs = s0.q[DW-1] ? (DW-1)'(-s0.q) : s0.q[DW-2:0];
    assign q_sq  = (2*DW-2)'(q_abs) * (2*DW-2)'(q_abs);

    // Only the top TAW+FW bits of the 2*DW-1 bit magnitude select index and fraction.
    assign mag2_kf = (TAW+FW)'(({1'b0, s1_i2} + {1'b0, s1_q2}) >> (2*DW-1-TAW-FW));

    // The last breakpoint pairs with itself, which forces a zero slope there.
    assign k_nxt = (s2_k == {TAW{1'b1}}) ? s2_k : s2_k + TAW'(1);

    assign dg  = (CW+1)'(s3_g1) - (CW+1)'(s3_g0);
    assign dp  = (CW+1)'(s3_p1) - (CW+1)'(s3_p0);
    assign f_s = {1'b0, s3_f};

    function automatic logic signed [DW-1:0] sat(input logic signed [DW+CW-1:0] prod);
        logic signed [DW+CW-1:0] sh;
        sh = prod >>> (CW-2);
        if (sh > SAT_MAX)      return DW'(SAT_MAX);
        else if (sh < SAT_MIN) return DW'(SAT_MIN);
        else                   return DW'(sh);
    endfunction

    // NOTE: every register here uses <= so each stage samples the previous stage's old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            err        <= 1'b0;
            s0_v       <= 1'b0;
            s1_v       <= 1'b0;
            s2_v       <= 1'b0;
            s3_v       <= 1'b0;
            s4_v       <= 1'b0;
            s5_v       <= 1'b0;
            s6_v       <= 1'b0;
            s0         <= '0;
            s1         <= '0;
            s2         <= '0;
            s3         <= '0;
            s4         <= '0;
            s5         <= '0;
            s0_mode    <= 1'b0;
            s1_mode    <= 1'b0;
            s2_mode    <= 1'b0;
            s0_i2      <= '0;
            s1_i2      <= '0;
            s1_q2      <= '0;
            s2_k       <= '0;
            s2_f       <= '0;
            s3_f       <= '0;
            s3_g0      <= '0;
            s3_g1      <= '0;
            s3_p0      <= '0;
            s3_p1      <= '0;
            s4_g0      <= '0;
            s4_p0      <= '0;
            s4_dg_prod <= '0;
            s4_dp_prod <= '0;
            s5_g       <= '0;
            s5_p       <= '0;
            s6_chan    <= '0;
            s6_prod_i  <= '0;
            s6_prod_q  <= '0;
            s6_angl    <= '0;
            o_valid    <= 1'b0;
            o_chan     <= '0;
            o_i        <= '0;
            o_q        <= '0;
            o_angl     <= '0;
        end else begin
            if (i_word)
                pending[i_chan] <= 1'b1;
            else if (q_hit)
                pending[i_chan] <= 1'b0;

            if (proto_err)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;

            // E0: accept Q word, pull the matching I slot
            s0_v      <= q_hit;
            s0_mode   <= mode;
            s0.chan   <= i_chan;
            s0.i      <= slot_i[i_chan];
            s0.q      <= i_cart;
            s0.angl   <= slot_angl[i_chan];
            s0_i2     <= slot_i2[i_chan];

            // E1: squares
            s1_v      <= s0_v;
            s1        <= s0;
            s1_mode   <= s0_mode;
            s1_i2     <= s0_i2;
            s1_q2     <= q_sq;

            // E2: magnitude, index/fraction split
            s2_v      <= s1_v;
            s2        <= s1;
            s2_mode   <= s1_mode;
            {s2_k, s2_f} <= mag2_kf;

            // E3: table read; bypass substitutes identity coefficients
            s3_v      <= s2_v;
            s3        <= s2;
            s3_f      <= s2_f;
            if (s2_mode) begin
                s3_g0 <= tbl_g[s2_k];
                s3_g1 <= tbl_g[k_nxt];
                s3_p0 <= tbl_p[s2_k];
                s3_p1 <= tbl_p[k_nxt];
            end else begin
                s3_g0 <= UNITY;
                s3_g1 <= UNITY;
                s3_p0 <= '0;
                s3_p1 <= '0;
            end

            // E4: slope times fraction
            s4_v       <= s3_v;
            s4         <= s3;
            s4_g0      <= s3_g0;
            s4_p0      <= s3_p0;
            s4_dg_prod <= (CW+FW+2)'(dg) * (CW+FW+2)'(f_s);
            s4_dp_prod <= (CW+FW+2)'(dp) * (CW+FW+2)'(f_s);

            // E5: interpolated value lies between the breakpoints, so CW bits suffice
            s5_v      <= s4_v;
            s5        <= s4;
            s5_g      <= s4_g0 + CW'(s4_dg_prod >>> FW);
            s5_p      <= s4_p0 + CW'(s4_dp_prod >>> FW);

            // E6: gain multiply and phase offset
            s6_v      <= s5_v;
            s6_chan   <= s5.chan;
            s6_prod_i <= (DW+CW)'($signed(s5.i)) * (DW+CW)'(s5_g);
            s6_prod_q <= (DW+CW)'($signed(s5.q)) * (DW+CW)'(s5_g);
            s6_angl   <= s5.angl + AW'($signed(s5_p));

            // E7: saturate; outputs hold between beats
            o_valid   <= s6_v;
            if (s6_v) begin
                o_chan <= s6_chan;
                o_i    <= sat(s6_prod_i);
                o_q    <= sat(s6_prod_q);
                o_angl <= s6_angl;
            end
        end
    end

endmodule

// File: tb/tb_lin_predist.sv
// Directed bench for lin_predist: hand-computed beats are queued at each Q word
// and matched against the output stream, including the latency of every beat.
module tb_lin_predist;

    localparam int NCH = 2;
    localparam int DW  = 16;
    localparam int AW  = 17;
    localparam int CW  = 16;
    localparam int TAW = 5;
    localparam int FW  = 8;
    localparam int CHW = 1;
    localparam int LAT = 7;

    logic                 clk;
    logic                 rst_n;
    logic                 i_valid;
    logic                 i_iq;
    logic [CHW-1:0]       i_chan;
    logic signed [DW-1:0] i_cart;
    logic [AW-1:0]        i_angl;
    logic                 mode;
    logic                 tbl_we;
    logic [TAW-1:0]       tbl_addr;
    logic [2*CW-1:0]      tbl_data;
    logic                 err_clr;
    logic                 o_valid;
    logic [CHW-1:0]       o_chan;
    logic signed [DW-1:0] o_i;
    logic signed [DW-1:0] o_q;
    logic [AW-1:0]        o_angl;
    logic                 err;

    lin_predist #(
        .NCH(NCH), .DW(DW), .AW(AW), .CW(CW), .TAW(TAW), .FW(FW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_iq(i_iq), .i_chan(i_chan), .i_cart(i_cart), .i_angl(i_angl),
        .mode(mode),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .err_clr(err_clr),
        .o_valid(o_valid), .o_chan(o_chan), .o_i(o_i), .o_q(o_q), .o_angl(o_angl),
        .err(err)
    );

    typedef struct {
        int chan;
        int i;
        int q;
        int angl;
        int due;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    n_checks = 0;
    int    n_errors = 0;
    int    n_beats  = 0;
    int    cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input bit iq, input int ch, input int cart, input int ang, input bit md);
        i_valid = 1'b1;
        i_iq    = iq;
        i_chan  = CHW'(ch);
        i_cart  = DW'(cart);
        i_angl  = AW'(ang);
        mode    = md;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Called right after the accepting send(); cyc then holds the accept edge.
    task automatic push(input int ch, input int ei, input int eq, input int ea);
        beat_t b;
        b.chan = ch;
        b.i    = ei;
        b.q    = eq;
        b.angl = ea;
        b.due  = cyc + LAT;
        exp_q.push_back(b);
    endtask

    task automatic tbl_write(input int addr, input int g, input int p);
        tbl_we   = 1'b1;
        tbl_addr = TAW'(addr);
        tbl_data = {CW'(g), CW'(p)};
        @(posedge clk);
        #1;
        tbl_we   = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            n_beats++;
            if (exp_q.size() == 0) begin
                check("extra_beat", o_valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat_chan", o_chan, mon_e.chan);
                check("beat_i", o_i, mon_e.i);
                check("beat_q", o_q, mon_e.q);
                check("beat_angl", o_angl, mon_e.angl);
                check("beat_latency", cyc, mon_e.due);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int iv[2];
        int av[2];
        int qv;
        int b0;

        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_iq     = 1'b0;
        i_chan   = '0;
        i_cart   = '0;
        i_angl   = '0;
        mode     = 1'b1;
        tbl_we   = 1'b0;
        tbl_addr = '0;
        tbl_data = '0;
        err_clr  = 1'b0;

        idle(3);
        check("rst_o_valid", o_valid, 0);
        check("rst_o_i", o_i, 0);
        check("rst_o_angl", o_angl, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        idle(2);

        // Identity table after reset
        send(0, 0, 1000, 5000, 1);
        send(1, 0, -2000, 0, 1);
        push(0, 1000, -2000, 5000);
        idle(12);
        check("drain_ident", exp_q.size(), 0);
        check("hold_valid", o_valid, 0);
        check("hold_i", o_i, 1000);
        check("hold_q", o_q, -2000);
        check("hold_angl", o_angl, 5000);
        check("err_clean", err, 0);

        // Protocol errors
        b0 = n_beats;
        send(1, 1, 123, 0, 1);
        check("orphan_q_err", err, 1);
        idle(10);
        check("orphan_q_nobeat", n_beats - b0, 0);
        pulse_clr();
        check("err_clr", err, 0);
        err_clr = 1'b1;
        send(1, 1, 5, 0, 1);
        err_clr = 1'b0;
        check("err_set_wins", err, 1);
        pulse_clr();
        send(0, 0, 500, 10, 1);
        check("dbl_i_first_ok", err, 0);
        send(0, 0, 700, 20, 1);
        check("dbl_i_err", err, 1);
        send(1, 0, 300, 0, 1);
        push(0, 700, 300, 20);
        idle(12);
        check("drain_dbl_i", exp_q.size(), 0);
        pulse_clr();

        // Interleaved frames I0 I1 Q0 Q1, back-to-back
        b0 = n_beats;
        for (int n = 0; n < 26; n++) begin
            for (int c = 0; c < 2; c++) begin
                iv[c] = int'($urandom_range(0, 60000)) - 30000;
                av[c] = int'($urandom_range(0, 131071));
                send(0, c, iv[c], av[c], 1);
            end
            for (int c = 0; c < 2; c++) begin
                qv = int'($urandom_range(0, 60000)) - 30000;
                send(1, c, qv, 0, 1);
                push(c, iv[c], qv, av[c]);
            end
        end
        idle(12);
        check("drain_tput", exp_q.size(), 0);
        check("tput_beats", n_beats - b0, 52);
        check("tput_err", err, 0);

        // Write landing on the read cycle returns the old entry (k=5, f=25)
        send(0, 0, 18500, 0, 1);
        send(1, 0, 0, 0, 1);
        push(0, 18500, 0, 0);
        idle(2);
        tbl_write(5, 8192, 0);
        send(0, 0, 18500, 0, 1);
        send(1, 0, 0, 0, 1);
        push(0, 10153, 0, 0);
        idle(12);
        check("drain_wr_rd", exp_q.size(), 0);

        // Interpolation k=2 f=64; 32767 is the largest gain the signed field holds
        tbl_write(2, 16384, 100);
        tbl_write(3, 32767, 300);
        send(0, 1, 12288, 1000, 1);
        send(1, 1, 0, 0, 1);
        push(1, 15359, 0, 1150);
        idle(12);
        // 0x8000 is gain -2.0: the slope -49152 needs the extra difference bit
        tbl_write(3, -32768, 300);
        send(0, 1, 12288, 1000, 1);
        send(1, 1, 0, 0, 1);
        push(1, 3072, 0, 1150);
        idle(12);
        check("drain_interp", exp_q.size(), 0);

        // Top breakpoint (k=31, slope ignored) and k=30 interpolating into it
        tbl_write(31, 8192, 0);
        send(0, 0, 32767, 0, 1);
        send(1, 0, 32767, 0, 1);
        push(0, 16383, 16383, 0);
        send(0, 1, -32767, 7, 1);
        send(1, 1, -32767, 0, 1);
        push(1, -16384, -16384, 7);
        send(0, 0, 32000, 0, 1);
        send(1, 0, 32000, 0, 1);
        push(0, 23750, 23750, 0);
        idle(12);
        check("drain_top", exp_q.size(), 0);

        // Saturation and angle wrap, then bypass over the same table entries
        tbl_write(11, 32767, 500);
        tbl_write(12, 32767, 500);
        send(0, 0, 20000, 131000, 1);
        send(1, 0, -20000, 0, 1);
        push(0, 32767, -32767, 428);
        send(0, 1, 20000, 131000, 1);
        send(1, 1, -20000, 0, 0);
        push(1, 20000, -20000, 131000);
        idle(12);
        check("drain_sat_byp", exp_q.size(), 0);

        // Reset with five beats in flight (first one on the output)
        send(0, 0, 20000, 1, 1);
        send(0, 1, 20000, 2, 1);
        send(1, 0, -20000, 0, 1);
        send(1, 1, -20000, 0, 1);
        send(0, 0, 20000, 3, 1);
        send(0, 1, 20000, 4, 1);
        send(1, 0, -20000, 0, 1);
        send(1, 1, -20000, 0, 1);
        send(0, 0, 20000, 5, 1);
        send(1, 0, -20000, 0, 1);
        check("inflight_valid", o_valid, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_i", o_i, 0);
        check("mid_rst_q", o_q, 0);
        check("mid_rst_angl", o_angl, 0);
        check("mid_rst_err", err, 0);
        idle(2);
        rst_n = 1'b1;
        b0 = n_beats;
        idle(12);
        check("post_rst_quiet", n_beats - b0, 0);

        // Table reads back as identity on previously written entries
        send(0, 0, 20000, 131000, 1);
        send(1, 0, -20000, 0, 1);
        push(0, 20000, -20000, 131000);
        send(0, 1, 12288, 1000, 1);
        send(1, 1, 0, 0, 1);
        push(1, 12288, 0, 1000);
        send(0, 0, 32767, 0, 1);
        send(1, 0, 32767, 0, 1);
        push(0, 32767, 32767, 0);
        idle(12);
        check("drain_post_rst", exp_q.size(), 0);

        // Reset clears a pending I slot
        send(0, 1, 100, 0, 1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        b0 = n_beats;
        send(1, 1, 200, 0, 1);
        check("pend_rst_err", err, 1);
        idle(10);
        check("pend_rst_nobeat", n_beats - b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
